// File: rtl/x86_membus_pkg.sv
// Shared definitions for the x86 core memory-bus responder: FSM encodings,
// default SRAM wait count and byte-lane selection.
package x86_membus_pkg;

    typedef enum logic [1:0] {
        mb_idle   = 2'd0,
        mb_access = 2'd1,
        mb_ack    = 2'd2
    } mb_state_t;

    localparam int MB_WAIT_DEFAULT = 2;

    // Lane pairs are ordered {ub_n, lb_n}, active-low.
    localparam logic [1:0] LANES_OFF  = 2'b11;
    localparam logic [1:0] LANES_BOTH = 2'b00;
    localparam logic [1:0] LANE_LO    = 2'b10;
    localparam logic [1:0] LANE_HI    = 2'b01;

    function automatic logic [1:0] lane_sel(input logic wr, input logic a0);
        if (!wr)
            return LANES_BOTH;
        return a0 ? LANE_HI : LANE_LO;
    endfunction

endpackage

// File: rtl/x86_membus.sv
// Byte-wide core memory port to 16-bit async SRAM bridge with programmable
// wait states, write-through and a one-word read cache.
module x86_membus
    import x86_membus_pkg::*;
#(
    parameter int WAIT = MB_WAIT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [19:0] address,
    input  logic        wr,
    input  logic [7:0]  i_data,
    output logic [7:0]  o_data,
    output logic        locked,
    output logic [18:0] sram_addr,
    input  logic [15:0] sram_dq_i,
    output logic [15:0] sram_dq_o,
    output logic        sram_dq_oe,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    localparam logic [2:0] WAIT_CNT = 3'(WAIT);

    mb_state_t   state;
    logic [2:0]  cnt;
    logic [15:0] cache_data;
    logic [18:0] cache_tag;
    logic        cache_valid;
    logic        wr_q;
    logic        a0_q;
    logic        hit;
    logic        tag_match;

    assign hit       = !wr && cache_valid && (cache_tag == address[19:1]);
    assign tag_match = cache_valid && (cache_tag == sram_addr);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= mb_idle;
            cnt         <= 3'd0;
            cache_valid <= 1'b0;
            locked      <= 1'b0;
            o_data      <= 8'd0;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_ub_n   <= 1'b1;
            sram_lb_n   <= 1'b1;
            sram_dq_oe  <= 1'b0;
            sram_addr   <= 19'd0;
        end else begin
            case (state)
                mb_idle: begin
                    sram_addr <= address[19:1];
                    a0_q      <= address[0];
                    wr_q      <= wr;
                    sram_dq_o <= {i_data, i_data};
                    if (hit) begin
                        state  <= mb_ack;
                        locked <= 1'b1;
                        o_data <= address[0] ? cache_data[15:8] : cache_data[7:0];
                    end else begin
                        state                  <= mb_access;
                        cnt                    <= 3'd0;
                        {sram_ub_n, sram_lb_n} <= lane_sel(wr, address[0]);
                        sram_oe_n              <= wr;
                        sram_we_n              <= !wr;
                        sram_dq_oe             <= wr;
                    end
                end
                mb_access: begin
                    if (cnt == WAIT_CNT) begin
                        state     <= mb_ack;
                        locked    <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        if (!wr_q) begin
                            cache_data  <= sram_dq_i;
                            cache_tag   <= sram_addr;
                            cache_valid <= 1'b1;
                            o_data      <= a0_q ? sram_dq_i[15:8] : sram_dq_i[7:0];
                        end else if (tag_match) begin
                            // Write-through keeps the cached word coherent; misses do not allocate.
                            if (a0_q)
                                cache_data[15:8] <= sram_dq_o[7:0];
                            else
                                cache_data[7:0]  <= sram_dq_o[7:0];
                        end
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                mb_ack: begin
                    // Write data stays driven through this cycle for SRAM hold time.
                    state                  <= mb_idle;
                    locked                 <= 1'b0;
                    sram_dq_oe             <= 1'b0;
                    {sram_ub_n, sram_lb_n} <= LANES_OFF;
                end
                default: begin
                    state <= mb_idle;
                end
            endcase
        end
    end

endmodule
